// File: rtl/rv_muldiv_seq_if.sv
// Control-side bundle between the M-extension sequencer and its ALU2 datapath.
interface rv_muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned CW = $clog2(XLEN);

  // Requests and datapath status toward the sequencer
  logic          i_flush;
  logic          i_start;
  logic [2:0]    i_funct3;
  logic          i_op1_sign;
  logic          i_op2_sign;
  logic          i_op2_zero;
  logic          i_carry;

  // Handshake and datapath strobes from the sequencer
  logic          o_ready;
  logic          o_busy;
  logic          o_load;
  logic          o_neg_op1;
  logic          o_neg_op2;
  logic          o_step;
  logic          o_sub;
  logic          o_restore;
  logic          o_neg_quot;
  logic          o_neg_rem;
  logic          o_div0;
  logic [1:0]    o_res_sel;
  logic [CW-1:0] o_cnt;
  logic          o_done;

  modport slave (
    input  i_flush, i_start, i_funct3, i_op1_sign, i_op2_sign, i_op2_zero, i_carry,
    output o_ready, o_busy, o_load, o_neg_op1, o_neg_op2, o_step, o_sub, o_restore,
           o_neg_quot, o_neg_rem, o_div0, o_res_sel, o_cnt, o_done
  );

  modport master (
    output i_flush, i_start, i_funct3, i_op1_sign, i_op2_sign, i_op2_zero, i_carry,
    input  o_ready, o_busy, o_load, o_neg_op1, o_neg_op2, o_step, o_sub, o_restore,
           o_neg_quot, o_neg_rem, o_div0, o_res_sel, o_cnt, o_done
  );
endinterface

// File: rtl/rv_muldiv_seq.sv
// Sequencer for the iterative MUL/DIV/REM datapath: walks LOAD/NEG/ITER/FIX/DONE
// and emits the datapath strobes. Holds only the op code, sign/zero flags and
// the iteration counter; operand data lives in the datapath.
module rv_muldiv_seq #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  rv_muldiv_seq_if.slave bus
);

  localparam int unsigned    CW       = $clog2(XLEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_NEG  = 3'd2;
  localparam logic [2:0] S_ITER = 3'd3;
  localparam logic [2:0] S_FIX  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          s1_q,     s1_d;
  logic          s2_q,     s2_d;
  logic          zero_q,   zero_d;

  logic is_div;
  logic is_sdiv;
  logic div0;

  // Op classification from the latched funct3 (bit 2 = div/rem, bit 0 = unsigned)
  assign is_div  = funct3_q[2];
  assign is_sdiv = funct3_q[2] & ~funct3_q[0];
  assign div0    = is_div & zero_q;

  // State, counter and latched op attributes
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct3_q <= 3'b000;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state, counter and op-latch logic; flush overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_flush) begin
          state_d  = S_LOAD;
          funct3_d = bus.i_funct3;
          s1_d     = bus.i_op1_sign;
          s2_d     = bus.i_op2_sign;
          zero_d   = bus.i_op2_zero;
        end
      end
      S_LOAD: begin
        if (div0 && (EARLY_OUT != 1'b0)) begin
          state_d = S_DONE;
        end else if (is_sdiv && (s1_q || s2_q)) begin
          state_d = S_NEG;
        end else begin
          state_d = S_ITER;
          cnt_d   = '0;
        end
      end
      S_NEG: begin
        state_d = S_ITER;
        cnt_d   = '0;
      end
      S_ITER: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Handshake and strobes decoded from the registered state
  assign bus.o_ready    = (state_q == S_IDLE);
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_load     = (state_q == S_LOAD);
  assign bus.o_neg_op1  = (state_q == S_NEG) & s1_q;
  assign bus.o_neg_op2  = (state_q == S_NEG) & s2_q;
  assign bus.o_step     = (state_q == S_ITER);
  assign bus.o_sub      = (state_q == S_ITER) & is_div;
  assign bus.o_restore  = (state_q == S_ITER) & is_div & ~bus.i_carry;
  assign bus.o_neg_quot = (state_q == S_FIX) & (funct3_q == 3'b100) & (s1_q ^ s2_q) & ~zero_q;
  assign bus.o_neg_rem  = (state_q == S_FIX) & (funct3_q == 3'b110) & s1_q;
  assign bus.o_div0     = (state_q != S_IDLE) & div0;
  assign bus.o_cnt      = cnt_q;
  assign bus.o_done     = (state_q == S_DONE) & ~bus.i_flush;

  // Result mux select: low product, high product, quotient, remainder
  assign bus.o_res_sel  = funct3_q[2] ? {1'b1, funct3_q[1]} : {1'b0, |funct3_q[1:0]};

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Scoreboard bench for rv_muldiv_seq: the driver pushes expected completions,
// the monitor counts strobes per op and checks them when o_done appears.
module tb_rv_muldiv_seq;

  logic clk;
  logic rst_n;

  rv_muldiv_seq_if #(.XLEN(32)) bus ();

  rv_muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int div0;
    int lat;
    int steps;
    int subs;
    int rest;
    int nop1;
    int nop2;
    int nquot;
    int nrem;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int last_done_cyc = 0;
  int ready_chk = 0;
  int c_load, c_step, c_sub, c_rest, c_nop1, c_nop2, c_nquot, c_nrem;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int sel, input int div0, input int lat, input int steps,
                              input int subs, input int rest, input int nop1, input int nop2,
                              input int nquot, input int nrem);
    exp_t e;
    e.sel = sel; e.div0 = div0; e.lat = lat; e.steps = steps; e.subs = subs;
    e.rest = rest; e.nop1 = nop1; e.nop2 = nop2; e.nquot = nquot; e.nrem = nrem;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: detect accepts, count strobes, compare on every o_done
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ready_chk != 0) begin
        check("ready_after_done", int'(bus.o_ready), 1);
        ready_chk = 0;
      end
      if (bus.o_ready && bus.i_start && !bus.i_flush) begin
        acc_cyc = cyc + 1;
        n_acc++;
        c_load = 0; c_step = 0; c_sub = 0; c_rest = 0;
        c_nop1 = 0; c_nop2 = 0; c_nquot = 0; c_nrem = 0;
      end
      if (bus.o_load)     c_load++;
      if (bus.o_step)     c_step++;
      if (bus.o_sub)      c_sub++;
      if (bus.o_restore)  c_rest++;
      if (bus.o_neg_op1)  c_nop1++;
      if (bus.o_neg_op2)  c_nop2++;
      if (bus.o_neg_quot) c_nquot++;
      if (bus.o_neg_rem)  c_nrem++;
      if (bus.o_done) begin
        n_done++;
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_done", int'(bus.o_done), 0);
        end else begin
          e = sb.pop_front();
          check("latency",  cyc - acc_cyc + 1, e.lat);
          check("res_sel",  int'(bus.o_res_sel), e.sel);
          check("div0",     int'(bus.o_div0), e.div0);
          check("loads",    c_load, 1);
          check("steps",    c_step, e.steps);
          check("subs",     c_sub, e.subs);
          check("restores", c_rest, e.rest);
          check("neg_op1",  c_nop1, e.nop1);
          check("neg_op2",  c_nop2, e.nop2);
          check("neg_quot", c_nquot, e.nquot);
          check("neg_rem",  c_nrem, e.nrem);
          ready_chk = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!bus.o_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_reached", int'(bus.o_ready), 1);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", n_done, target);
  endtask

  // One op: push expectation, pulse start, scramble request inputs after accept
  task automatic run_op(input logic [2:0] f3, input logic s1, input logic s2,
                        input logic z, input logic c, input exp_t e);
    int target;
    wait_idle();
    sb.push_back(e);
    target = n_done + 1;
    bus.i_start = 1'b1; bus.i_funct3 = f3;
    bus.i_op1_sign = s1; bus.i_op2_sign = s2; bus.i_op2_zero = z; bus.i_carry = c;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_funct3 = ~f3;
    bus.i_op1_sign = ~s1; bus.i_op2_sign = ~s2; bus.i_op2_zero = ~z;
    wait_done(target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d, base, k;
    rst_n = 1'b0;
    bus.i_flush = 1'b0; bus.i_start = 1'b0; bus.i_funct3 = 3'b000;
    bus.i_op1_sign = 1'b0; bus.i_op2_sign = 1'b0; bus.i_op2_zero = 1'b0; bus.i_carry = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   int'(bus.o_ready), 1);
    check("rst_busy",    int'(bus.o_busy), 0);
    check("rst_cnt",     int'(bus.o_cnt), 0);
    check("rst_done",    int'(bus.o_done), 0);
    check("rst_res_sel", int'(bus.o_res_sel), 0);
    check("rst_div0",    int'(bus.o_div0), 0);
    check("rst_load",    int'(bus.o_load), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MUL 7*6
    run_op(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 35, 32, 0, 0, 0, 0, 0, 0));
    // MULH -1*-1, carry low must not produce restores for a multiply
    run_op(3'b001, 1'b1, 1'b1, 1'b0, 1'b0, mk(1, 0, 35, 32, 0, 0, 0, 0, 0, 0));
    // DIV -7/2, every trial subtract borrows
    run_op(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, mk(2, 0, 36, 32, 32, 32, 1, 0, 1, 0));
    // REM -7/2
    run_op(3'b110, 1'b1, 1'b0, 1'b0, 1'b1, mk(3, 0, 36, 32, 32, 0, 1, 0, 0, 1));
    // DIV -7/-2: both negated, quotient positive
    run_op(3'b100, 1'b1, 1'b1, 1'b0, 1'b1, mk(2, 0, 36, 32, 32, 0, 1, 1, 0, 0));
    // DIV 7/2 positive: no NEG cycle
    run_op(3'b100, 1'b0, 1'b0, 1'b0, 1'b1, mk(2, 0, 35, 32, 32, 0, 0, 0, 0, 0));
    // REMU with borrows
    run_op(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, mk(3, 0, 35, 32, 32, 32, 0, 0, 0, 0));
    // DIVU x/0 early out
    run_op(3'b101, 1'b0, 1'b0, 1'b1, 1'b1, mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    // Signed DIV -x/0 early out: no NEG, no quotient negate
    run_op(3'b100, 1'b1, 1'b0, 1'b1, 1'b1, mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0));

    // Flush during DIVU at o_cnt==10: no completion expected
    wait_idle();
    bus.i_start = 1'b1; bus.i_funct3 = 3'b101;
    bus.i_op1_sign = 1'b0; bus.i_op2_sign = 1'b0; bus.i_op2_zero = 1'b0; bus.i_carry = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    k = 0;
    while (!(bus.o_step && bus.o_cnt == 5'd10) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("flush_cnt_reached", int'(bus.o_cnt), 10);
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    check("flush_ready", int'(bus.o_ready), 1);
    check("flush_cnt",   int'(bus.o_cnt), 0);
    repeat (40) @(posedge clk);
    #1;
    // New op accepted after flush
    run_op(3'b101, 1'b0, 1'b0, 1'b1, 1'b1, mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0));

    // Start held high across two MULs
    wait_idle();
    sb.push_back(mk(0, 0, 35, 32, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 35, 32, 0, 0, 0, 0, 0, 0));
    a0 = n_acc;
    base = n_done;
    bus.i_start = 1'b1; bus.i_funct3 = 3'b000;
    bus.i_op1_sign = 1'b0; bus.i_op2_sign = 1'b0; bus.i_op2_zero = 1'b0; bus.i_carry = 1'b1;
    wait_done(base + 1);
    d = last_done_cyc;
    k = 0;
    while (!bus.o_busy && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    bus.i_start = 1'b0;
    check("b2b_accept_gap", acc_cyc - d, 2);
    wait_done(base + 2);
    check("b2b_accepts", n_acc - a0, 2);

    // Flush and start together in IDLE: flush wins
    wait_idle();
    a0 = n_acc;
    bus.i_start = 1'b1; bus.i_flush = 1'b1;
    @(posedge clk); #1;
    check("flush_start_busy", int'(bus.o_busy), 0);
    bus.i_start = 1'b0; bus.i_flush = 1'b0;
    check("flush_start_acc", n_acc - a0, 0);

    // Async reset mid-op: immediate IDLE, no completion
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_funct3 = 3'b000;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(bus.o_busy), 0);
    check("async_rst_cnt",  int'(bus.o_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
